// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch, decode, execute, memory and writeback.
// Memory states hold while mem_ready is low. The ALU decoder is folded into the output decode.
module mc_controller #(
    parameter int OPW = 6,
    parameter int FW  = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [FW-1:0]  funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pcen,
    output logic           iord,
    output logic           mem_req,
    output logic           memwrite,
    output logic           irwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [2:0]     alucontrol,
    output logic           illegal_op,
    output logic [3:0]     state_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

    localparam logic [FW-1:0] FN_ADD = FW'(6'b100000);
    localparam logic [FW-1:0] FN_SUB = FW'(6'b100010);
    localparam logic [FW-1:0] FN_AND = FW'(6'b100100);
    localparam logic [FW-1:0] FN_OR  = FW'(6'b100101);
    localparam logic [FW-1:0] FN_SLT = FW'(6'b101010);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t r_state;
    state_t w_next;

    function automatic logic [2:0] funct_dec(input logic [FW-1:0] f);
        case (f)
            FN_ADD:  return 3'b010;
            FN_SUB:  return 3'b110;
            FN_AND:  return 3'b000;
            FN_OR:   return 3'b001;
            FN_SLT:  return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = FETCH;
        pcen       = 1'b0;
        iord       = 1'b0;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        illegal_op = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                w_next  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYP:      w_next = EXECUTE;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JUMP;
                    default: begin
                        w_next     = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                w_next  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                w_next   = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_dec(funct);
                w_next     = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: alucontrol = 3'b000;
        endcase
        // Reset drops the state to FETCH asynchronously; also mask every strobe while it is held.
        if (reset) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            mem_req    = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes hand-computed output vectors per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, iord, mem_req, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    mc_controller #(.OPW(6), .FW(6)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .mem_req(mem_req),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // {state, pcen iord mem_req memwrite irwrite regdst memtoreg regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal_op}
    logic [20:0] w_act;
    assign w_act = {state_o, pcen, iord, mem_req, memwrite, irwrite, regdst, memtoreg,
                    regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal_op};

    function automatic logic [20:0] mk(input logic [3:0] st, input logic [7:0] en,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] pcs, input logic [2:0] alu,
                                       input logic ill);
        return {st, en, asa, asb, pcs, alu, ill};
    endfunction

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    // Hand-computed per-state vectors
    logic [20:0] E_RST, E_F1, E_F0, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR, E_ALUWB;
    logic [20:0] E_BR1, E_BR0, E_AEX, E_AWB, E_JMP, E_ILL, E_EX_SLT, E_EX_SUB;

    initial begin
        E_RST    = mk(4'd0,  8'b0000_0000, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0);
        E_F1     = mk(4'd0,  8'b1010_1000, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0);
        E_F0     = mk(4'd0,  8'b0010_0000, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0);
        E_DEC    = mk(4'd1,  8'b0000_0000, 1'b0, 2'b11, 2'b00, 3'b010, 1'b0);
        E_ILL    = mk(4'd1,  8'b0000_0000, 1'b0, 2'b11, 2'b00, 3'b010, 1'b1);
        E_MADR   = mk(4'd2,  8'b0000_0000, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0);
        E_MRD    = mk(4'd3,  8'b0110_0000, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0);
        E_MWB    = mk(4'd4,  8'b0000_0011, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0);
        E_MWR    = mk(4'd5,  8'b0111_0000, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0);
        E_EX_SLT = mk(4'd6,  8'b0000_0000, 1'b1, 2'b00, 2'b00, 3'b111, 1'b0);
        E_EX_SUB = mk(4'd6,  8'b0000_0000, 1'b1, 2'b00, 2'b00, 3'b110, 1'b0);
        E_ALUWB  = mk(4'd7,  8'b0000_0101, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0);
        E_BR1    = mk(4'd8,  8'b1000_0000, 1'b1, 2'b00, 2'b01, 3'b110, 1'b0);
        E_BR0    = mk(4'd8,  8'b0000_0000, 1'b1, 2'b00, 2'b01, 3'b110, 1'b0);
        E_AEX    = mk(4'd9,  8'b0000_0000, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0);
        E_AWB    = mk(4'd10, 8'b0000_0001, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0);
        E_JMP    = mk(4'd11, 8'b1000_0000, 1'b0, 2'b00, 2'b10, 3'b010, 1'b0);
    end

    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic mr, input logic [20:0] e, input string n);
        exp_t x;
        @(posedge clk);
        #1;
        reset = r; op = o; funct = f; zero = z; mem_ready = mr;
        x.v = e; x.name = n;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            total++;
            if (w_act !== x.v) begin
                bad++;
                $display("FAIL %s: got %b required %b", x.name, w_act, x.v);
            end
        end
    end

    initial begin
        exp_t x;
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        step(1, LW, 6'd0, 0, 1, E_RST, "reset_hold");
        // lw, no wait states
        step(0, LW, 6'd0, 0, 1, E_F1,   "lw_fetch");
        step(0, LW, 6'd0, 0, 1, E_DEC,  "lw_decode");
        step(0, LW, 6'd0, 0, 1, E_MADR, "lw_memadr");
        step(0, LW, 6'd0, 0, 1, E_MRD,  "lw_memrd");
        step(0, LW, 6'd0, 0, 1, E_MWB,  "lw_memwb");
        // sw with three wait cycles, preceded by one fetch stall
        step(0, SW, 6'd0, 0, 0, E_F0,   "sw_fetch_stall");
        step(0, SW, 6'd0, 0, 1, E_F1,   "sw_fetch");
        step(0, SW, 6'd0, 0, 1, E_DEC,  "sw_decode");
        step(0, SW, 6'd0, 0, 1, E_MADR, "sw_memadr");
        step(0, SW, 6'd0, 0, 0, E_MWR,  "sw_memwr_wait1");
        step(0, SW, 6'd0, 0, 0, E_MWR,  "sw_memwr_wait2");
        step(0, SW, 6'd0, 0, 0, E_MWR,  "sw_memwr_wait3");
        step(0, SW, 6'd0, 0, 1, E_MWR,  "sw_memwr_done");
        // R-type slt then sub
        step(0, RT, 6'b101010, 0, 1, E_F1,     "slt_fetch");
        step(0, RT, 6'b101010, 0, 1, E_DEC,    "slt_decode");
        step(0, RT, 6'b101010, 0, 1, E_EX_SLT, "slt_execute");
        step(0, RT, 6'b101010, 0, 1, E_ALUWB,  "slt_aluwb");
        step(0, RT, 6'b100010, 0, 1, E_F1,     "sub_fetch");
        step(0, RT, 6'b100010, 0, 1, E_DEC,    "sub_decode");
        step(0, RT, 6'b100010, 0, 1, E_EX_SUB, "sub_execute");
        step(0, RT, 6'b100010, 0, 1, E_ALUWB,  "sub_aluwb");
        // beq taken / not taken
        step(0, BEQ, 6'd0, 1, 1, E_F1,  "beq1_fetch");
        step(0, BEQ, 6'd0, 1, 1, E_DEC, "beq1_decode");
        step(0, BEQ, 6'd0, 1, 1, E_BR1, "beq1_branch");
        step(0, BEQ, 6'd0, 0, 1, E_F1,  "beq0_fetch");
        step(0, BEQ, 6'd0, 0, 1, E_DEC, "beq0_decode");
        step(0, BEQ, 6'd0, 0, 1, E_BR0, "beq0_branch");
        // addi, j
        step(0, ADDI, 6'd0, 0, 1, E_F1,  "addi_fetch");
        step(0, ADDI, 6'd0, 0, 1, E_DEC, "addi_decode");
        step(0, ADDI, 6'd0, 0, 1, E_AEX, "addi_ex");
        step(0, ADDI, 6'd0, 0, 1, E_AWB, "addi_wb");
        step(0, JMP,  6'd0, 0, 1, E_F1,  "j_fetch");
        step(0, JMP,  6'd0, 0, 1, E_DEC, "j_decode");
        step(0, JMP,  6'd0, 0, 1, E_JMP, "j_jump");
        // illegal opcode: one-cycle pulse, then back to FETCH
        step(0, 6'b111111, 6'd0, 0, 1, E_F1,  "ill_fetch");
        step(0, 6'b111111, 6'd0, 0, 1, E_ILL, "ill_decode");
        step(0, 6'b111111, 6'd0, 0, 0, E_F0,  "ill_next_fetch");
        // sw interrupted by reset while in MEMWR with mem_ready high
        step(0, SW, 6'd0, 0, 1, E_F1,   "rst_sw_fetch");
        step(0, SW, 6'd0, 0, 1, E_DEC,  "rst_sw_decode");
        step(0, SW, 6'd0, 0, 1, E_MADR, "rst_sw_memadr");
        @(posedge clk);
        #2;
        reset = 1'b1;
        x.v = E_RST; x.name = "rst_in_memwr";
        exp_q.push_back(x);
        step(1, SW, 6'd0, 0, 1, E_RST, "rst_held");
        step(0, SW, 6'd0, 0, 0, E_F0,  "post_rst_fetch_stall");
        step(0, SW, 6'd0, 0, 1, E_F1,  "post_rst_fetch");
        step(0, SW, 6'd0, 0, 1, E_DEC, "post_rst_decode");
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit: a Moore FSM that sequences the shared single-memory/single-ALU datapath through fetch, decode, execute, memory and writeback.
- Generates every mux select and write enable, including the PC register load enable `pcen`.
- Contains the ALU decoder.
- Adds a memory wait-state handshake (`mem_ready`) so that slow memory stalls the sequence.

Parameters:
- OPW, 6, opcode field width
- FW, 6, funct field width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- op  input  OPW  instruction opcode (IR[31:26])
- funct  input  FW  function field (IR[5:0])
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- pcen  output  1  PC register load enable
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_req  output  1  memory access request
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- regdst  output  1  destination: 0=rt, 1=rd
- memtoreg  output  1  writeback data: 0=ALUOut, 1=MDR
- regwrite  output  1  register file write
- alusrca  output  1  ALU A: 0=PC, 1=A reg
- alusrcb  output  2  ALU B: 00=B, 01=4, 10=signimm, 11=signimm<<2
- pcsrc  output  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU operation
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state_o  output  4  current state, for debug

Behaviour:
- State register
  - 4 bits, asynchronous reset to FETCH.
  - All outputs are decoded combinationally from the state, plus `mem_ready`, `zero` and `funct` where noted.
  - While `reset`=1, `pcen`, `irwrite`, `regwrite`, `memwrite`, `mem_req` and `illegal_op` are forced to 0.
  - Other outputs take their FETCH values during reset.
- Default value for every output in every state is 0 unless listed below.
- FETCH
  - Outputs: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, aluop=ADD, `pcsrc`=00.
  - `irwrite`=`pcen`=`mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE
  - Outputs: `alusrca`=0, `alusrcb`=11, aluop=ADD (branch target into ALUOut).
  - Next state by opcode:
    - 100011 (lw) -> MEMADR
    - 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with `illegal_op`=1 for this cycle only.
- MEMADR
  - Outputs: `alusrca`=1, `alusrcb`=10, aluop=ADD.
  - Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD
  - Outputs: `mem_req`=1, `iord`=1.
  - Holds until `mem_ready`=1, then -> MEMWB.
- MEMWB
  - Outputs: `regdst`=0, `memtoreg`=1, `regwrite`=1.
  - Next state: FETCH.
- MEMWR
  - Outputs: `mem_req`=1, `iord`=1, `memwrite`=1 (held through all wait cycles).
  - Holds until `mem_ready`=1, then -> FETCH.
- EXECUTE
  - Outputs: `alusrca`=1, `alusrcb`=00, aluop=FUNCT.
  - Next state: ALUWB.
- ALUWB
  - Outputs: `regdst`=1, `memtoreg`=0, `regwrite`=1.
  - Next state: FETCH.
- BRANCH
  - Outputs: `alusrca`=1, `alusrcb`=00, aluop=SUB, `pcsrc`=01.
  - `pcen`=`zero`.
  - Next state: FETCH.
- ADDIEX
  - Outputs: `alusrca`=1, `alusrcb`=10, aluop=ADD.
  - Next state: ADDIWB.
- ADDIWB
  - Outputs: `regdst`=0, `memtoreg`=0, `regwrite`=1.
  - Next state: FETCH.
- JUMP
  - Outputs: `pcsrc`=10, `pcen`=1.
  - Next state: FETCH.
- ALU decode
  - ADD -> 010; SUB -> 110.
  - FUNCT mapping:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - any other funct -> 010
  - In states that use no aluop, `alucontrol`=010.
- Latency with zero wait states:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq, j = 3 cycles
  - Each `mem_ready`=0 cycle adds 1 cycle.
- Unused state encodings fall through to FETCH on the next edge; all outputs are 0 in those encodings.
- Reset asserted mid-instruction takes effect immediately (asynchronous): state=FETCH and no write enable is asserted on the following edge. This holds even if the FSM was in MEMWR with `mem_ready`=1.
- `op` and `funct` are sampled only in DECODE, MEMADR and EXECUTE. The IR holds them stable because `irwrite` is 0 outside FETCH.

Test Plan:
- Reset, then lw (op=100011) with `mem_ready`=1 held -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; `regwrite`=1 and `memtoreg`=1 only in cycle 5; `pcen`=1 only in cycle 1.
- sw with `mem_ready`=0 for 3 cycles in MEMWR -> `memwrite`=`mem_req`=`iord`=1 for 4 cycles, then FETCH; `regwrite` never 1.
- R-type, funct=101010, then funct=100010 -> `alucontrol`=111 in EXECUTE for the first instruction and 110 for the second; `regdst`=1 in ALUWB.
- beq with zero=1, then beq with zero=0 -> `pcen`=1 / `pcsrc`=01 in BRANCH for the first; `pcen`=0 in BRANCH for the second.
- op=111111 -> `illegal_op`=1 for exactly one cycle in DECODE; next state FETCH; no write enables asserted.
- Assert reset during MEMWR with `mem_ready`=1 -> `memwrite`=0 immediately and `state_o`=FETCH; after release, fetch resumes with `pcen` gated by `mem_ready`.
